// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, parity engine state encoding and
// the data-length field width helper.
package uart_pkg;

   localparam logic [1:0] PAR_EVEN  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_MARK  = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ACCUM    = 2'b01,
      ST_WAIT_PAR = 2'b10
   } par_state_t;

   // Width needed to hold a bit count of 0..data_width inclusive.
   function automatic int calc_len_w(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/par_err_counter.sv
// Saturating parity-error counter with synchronous clear; clear beats increment.
module par_err_counter #(
   parameter int W = 8
)(
   input  logic         CLK,
   input  logic         RST,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/parity_serial_engine.sv
// Serial parity generator/checker for the UART TX/RX paths.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt output and err_cnt_clr input.
module parity_serial_engine
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = calc_len_w(DATA_WIDTH)
`ifdef PARITY_ERR_CNT_EN
   ,
   parameter int ERR_CNT_W  = 8
`endif
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             PAR_EN,
   input  logic [1:0]       PAR_MODE,
   input  logic [LEN_W-1:0] data_len,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             par_sample_valid,
   input  logic             par_sample,
`ifdef PARITY_ERR_CNT_EN
   input  logic                 err_cnt_clr,
   output logic [ERR_CNT_W-1:0] err_cnt,
`endif
   output logic             par_bit,
   output logic             par_ready,
   output logic             par_err,
   output logic             done,
   output logic             busy
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

   par_state_t       state, state_n;
   logic             acc, acc_n;
   logic [LEN_W-1:0] cnt, cnt_n;
   logic [LEN_W-1:0] len_q, len_n;
   logic [LEN_W-1:0] eff_len;
   logic             par_en_q, par_en_n;
   logic [1:0]       mode_q, mode_n;
   logic             par_bit_n, par_ready_n, par_err_n, done_n;
   logic             acc_final, last_bit, par_calc;

   // A zero or oversized length means a full-width frame.
   assign eff_len   = ((data_len == '0) || (data_len > MAX_LEN)) ? MAX_LEN : data_len;
   assign acc_final = acc ^ bit_in;
   assign last_bit  = (cnt == (len_q - LEN_W'(1)));
   assign busy      = (state == ST_ACCUM) || (state == ST_WAIT_PAR);

   always_comb begin
      par_calc = acc_final;
      case (mode_q)
         PAR_EVEN:  par_calc = acc_final;
         PAR_ODD:   par_calc = ~acc_final;
         PAR_MARK:  par_calc = 1'b1;
         PAR_SPACE: par_calc = 1'b0;
         default:   par_calc = acc_final;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         acc       <= 1'b0;
         cnt       <= '0;
         len_q     <= '0;
         par_en_q  <= 1'b0;
         mode_q    <= PAR_EVEN;
         par_bit   <= 1'b1;
         par_ready <= 1'b0;
         par_err   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         cnt       <= cnt_n;
         len_q     <= len_n;
         par_en_q  <= par_en_n;
         mode_q    <= mode_n;
         par_bit   <= par_bit_n;
         par_ready <= par_ready_n;
         par_err   <= par_err_n;
         done      <= done_n;
      end
   end

   // start overrides every state, so an in-flight frame is silently abandoned.
   always_comb begin
      state_n     = state;
      acc_n       = acc;
      cnt_n       = cnt;
      len_n       = len_q;
      par_en_n    = par_en_q;
      mode_n      = mode_q;
      par_bit_n   = par_bit;
      par_ready_n = par_ready;
      par_err_n   = par_err;
      done_n      = 1'b0;

      if (start) begin
         state_n     = ST_ACCUM;
         acc_n       = 1'b0;
         cnt_n       = '0;
         len_n       = eff_len;
         par_en_n    = PAR_EN;
         mode_n      = PAR_MODE;
         par_ready_n = 1'b0;
         par_err_n   = 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (bit_valid) begin
                  acc_n = acc_final;
                  cnt_n = cnt + LEN_W'(1);
                  if (last_bit) begin
                     par_bit_n   = par_calc;
                     par_ready_n = 1'b1;
                     if (par_en_q) begin
                        state_n = ST_WAIT_PAR;
                     end else begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                     end
                  end
               end
            end
            ST_WAIT_PAR: begin
               if (par_sample_valid) begin
                  par_err_n = (par_sample != par_bit);
                  done_n    = 1'b1;
                  state_n   = ST_IDLE;
               end
            end
            default: begin
               state_n = state;
            end
         endcase
      end
   end

`ifdef PARITY_ERR_CNT_EN
   logic err_inc;

   assign err_inc = !start && (state == ST_WAIT_PAR) && par_sample_valid &&
                    (par_sample != par_bit);

   par_err_counter #(
      .W(ERR_CNT_W)
   ) u_err_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (err_cnt_clr),
      .inc   (err_inc),
      .count (err_cnt)
   );
`else
   // Without the counter a parity error is visible only on par_err until the next start.
`endif

endmodule

// File: tb/tb_parity_serial_engine.sv
// Self-checking bench for parity_serial_engine: directed frames plus random frames
// checked against a count-the-ones parity model.
module tb_parity_serial_engine;

   localparam int DW    = 8;
   localparam int LEN_W = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             start = 1'b0;
   logic             PAR_EN = 1'b0;
   logic [1:0]       PAR_MODE = 2'b00;
   logic [LEN_W-1:0] data_len = '0;
   logic             bit_valid = 1'b0;
   logic             bit_in = 1'b0;
   logic             par_sample_valid = 1'b0;
   logic             par_sample = 1'b0;
   logic             par_bit, par_ready, par_err, done, busy;
`ifdef PARITY_ERR_CNT_EN
   logic             err_cnt_clr = 1'b0;
   logic [7:0]       err_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   int err_model = 0;

   parity_serial_engine #(.DATA_WIDTH(DW)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .start            (start),
      .PAR_EN           (PAR_EN),
      .PAR_MODE         (PAR_MODE),
      .data_len         (data_len),
      .bit_valid        (bit_valid),
      .bit_in           (bit_in),
      .par_sample_valid (par_sample_valid),
      .par_sample       (par_sample),
`ifdef PARITY_ERR_CNT_EN
      .err_cnt_clr      (err_cnt_clr),
      .err_cnt          (err_cnt),
`endif
      .par_bit          (par_bit),
      .par_ready        (par_ready),
      .par_err          (par_err),
      .done             (done),
      .busy             (busy)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (RST && (done === 1'b1)) done_count++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Parity from the frame's rules: count the ones, then apply the mode.
   function automatic logic expParity(input logic [1:0] mode, input logic [15:0] data,
                                      input int n);
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(data[i]);
      case (mode)
         2'b00:   return (ones % 2) == 1;
         2'b01:   return (ones % 2) == 0;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic startFrame(input logic en, input logic [1:0] mode, input int len_field,
                             input logic collide);
      @(negedge CLK);
      start    = 1'b1;
      PAR_EN   = en;
      PAR_MODE = mode;
      data_len = LEN_W'(len_field);
      if (collide) begin
         bit_valid = 1'b1;
         bit_in    = 1'b1;
      end
      @(negedge CLK);
      start     = 1'b0;
      bit_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic en, input logic [1:0] mode, input int len_field,
                                input logic [15:0] data, input int gap, input logic sample,
                                input logic collide);
      int   eff;
      int   d0;
      logic exp_bit;
      eff     = (len_field == 0 || len_field > DW) ? DW : len_field;
      exp_bit = expParity(mode, data, eff);
      startFrame(en, mode, len_field, collide);
      d0 = done_count;
      checkOutput("busy_after_start", busy, 1);
      checkOutput("ready_cleared", par_ready, 0);
      checkOutput("err_cleared", par_err, 0);
      for (int i = 0; i < eff; i++) begin
         bit_valid = 1'b1;
         bit_in    = data[i];
         @(negedge CLK);
         bit_valid = 1'b0;
         if (i < eff - 1) begin
            checkOutput("ready_before_last", par_ready, 0);
            for (int g = 0; g < gap; g++) begin
               par_sample_valid = 1'b1;
               par_sample       = 1'($urandom);
               @(negedge CLK);
               par_sample_valid = 1'b0;
            end
         end
      end
      checkOutput("par_ready", par_ready, 1);
      checkOutput("par_bit", par_bit, exp_bit);
      if (!en) begin
         checkOutput("done_no_par", done, 1);
         checkOutput("busy_no_par", busy, 0);
         checkOutput("err_no_par", par_err, 0);
         par_sample_valid = 1'b1;
         par_sample       = ~exp_bit;
         @(negedge CLK);
         par_sample_valid = 1'b0;
         checkOutput("done_clear_no_par", done, 0);
         checkOutput("err_ignored_sample", par_err, 0);
         checkOutput("ready_hold", par_ready, 1);
      end else begin
         checkOutput("done_wait_par", done, 0);
         checkOutput("busy_wait_par", busy, 1);
         repeat (gap) @(negedge CLK);
         par_sample_valid = 1'b1;
         par_sample       = sample;
         @(negedge CLK);
         par_sample_valid = 1'b0;
         checkOutput("done_after_sample", done, 1);
         checkOutput("par_err", par_err, (sample != exp_bit));
         checkOutput("busy_after_sample", busy, 0);
         checkOutput("par_bit_hold", par_bit, exp_bit);
`ifdef PARITY_ERR_CNT_EN
         if ((sample != exp_bit) && (err_model < 255)) err_model++;
         checkOutput("err_cnt", err_cnt, err_model);
`endif
         @(negedge CLK);
         checkOutput("done_pulse_end", done, 0);
         checkOutput("par_err_hold", par_err, (sample != exp_bit));
      end
      checkOutput("done_pulse_count", done_count - d0, 1);
   endtask

   initial begin
      logic        r_en;
      logic [1:0]  r_mode;
      int          r_len;
      logic [15:0] r_data;
      int          r_gap;
      logic        r_sample;

      // Reset values
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("rst_par_bit", par_bit, 1);
      checkOutput("rst_par_ready", par_ready, 0);
      checkOutput("rst_par_err", par_err, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_busy", busy, 0);
`ifdef PARITY_ERR_CNT_EN
      checkOutput("rst_err_cnt", err_cnt, 0);
`endif
      RST = 1'b1;
      @(negedge CLK);

      // Directed frames
      applyStimulus(1'b1, 2'b00, 8, 16'h000D, 0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b01, 5, 16'h0003, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 7, 16'h0055, 3, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b11, 7, 16'h0055, 3, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 0, 16'h0001, 0, 1'b0, 1'b0);

      // bit_valid while idle must not disturb held results
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      @(negedge CLK);
      bit_valid = 1'b0;
      checkOutput("idle_bit_busy", busy, 0);
      checkOutput("idle_bit_par", par_bit, 1);
      checkOutput("idle_bit_ready", par_ready, 1);

      // Abort after 3 bits, restart with a colliding bit_valid
      startFrame(1'b1, 2'b00, 8, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1;
         bit_in    = 1'b1;
         @(negedge CLK);
         bit_valid = 1'b0;
      end
      applyStimulus(1'b1, 2'b00, 8, 16'h00FF, 0, 1'b0, 1'b1);

      // Random frames
      for (int k = 0; k < 25; k++) begin
         r_en     = 1'($urandom_range(0, 1));
         r_mode   = 2'($urandom_range(0, 3));
         r_len    = $urandom_range(0, 15);
         r_data   = 16'($urandom);
         r_gap    = $urandom_range(0, 2);
         r_sample = 1'($urandom_range(0, 1));
         applyStimulus(r_en, r_mode, r_len, r_data, r_gap, r_sample, 1'b0);
      end

      // Asynchronous reset while waiting for the parity sample
      startFrame(1'b1, 2'b00, 4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bit_valid = 1'b1;
         bit_in    = (i < 2);
         @(negedge CLK);
         bit_valid = 1'b0;
      end
      checkOutput("pre_rst_busy", busy, 1);
      checkOutput("pre_rst_par_bit", par_bit, 0);
      #2;
      RST = 1'b0;
      #1;
      checkOutput("async_rst_par_bit", par_bit, 1);
      checkOutput("async_rst_ready", par_ready, 0);
      checkOutput("async_rst_busy", busy, 0);
      checkOutput("async_rst_err", par_err, 0);
      err_model = 0;
`ifdef PARITY_ERR_CNT_EN
      checkOutput("async_rst_err_cnt", err_cnt, 0);
`endif
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

`ifdef PARITY_ERR_CNT_EN
      // Saturation, then clear coincident with an error
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'b1, 2'b00, 1, 16'h0000, 0, 1'b1, 1'b0);
      end
      checkOutput("err_cnt_saturated", err_cnt, 255);
      startFrame(1'b1, 2'b00, 1, 1'b0);
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      @(negedge CLK);
      bit_valid        = 1'b0;
      par_sample_valid = 1'b1;
      par_sample       = 1'b1;
      err_cnt_clr      = 1'b1;
      @(negedge CLK);
      par_sample_valid = 1'b0;
      err_cnt_clr      = 1'b0;
      checkOutput("clr_wins_err", par_err, 1);
      checkOutput("clr_wins_cnt", err_cnt, 0);
      err_model = 0;
`endif

      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/parity_serial_engine.md
Name: parity_serial_engine

Overview:
Parametrised serial parity generator/checker for the UART TX and RX paths. It accumulates parity one bit at a time as frame data bits shift past, over a runtime frame length of 1..DATA_WIDTH. It supports even, odd, mark and space modes. On RX it compares the received parity bit against the computed value and flags a mismatch; on TX the computed par_bit feeds the serializer mux.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (legal range 1..16)
LEN_W, $clog2(DATA_WIDTH+1), width of the data_len field; derived, must not be overridden
ERR_CNT_W, 8, width of the error counter (optional feature only)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a new frame and latches the config inputs
PAR_EN  in  1  1 = frame carries a parity bit; sampled on start
PAR_MODE  in  2  00 even, 01 odd, 10 mark, 11 space; sampled on start
data_len  in  LEN_W  number of data bits in the frame; sampled on start
bit_valid  in  1  qualifies bit_in for one data bit
bit_in  in  1  serial data bit
par_sample_valid  in  1  qualifies par_sample (RX parity bit slot)
par_sample  in  1  received parity bit
par_bit  out  1  computed parity bit; valid while par_ready=1
par_ready  out  1  computed parity available
par_err  out  1  parity mismatch for the last checked frame
done  out  1  one-cycle pulse at frame completion
busy  out  1  high in ACCUM and WAIT_PAR

Behaviour:
- Reset values: par_bit=1 (idle-line level), par_ready=0, par_err=0, done=0, busy=0, state=IDLE, accumulator=0, bit count=0.
- States:
  - IDLE: waits for start.
  - ACCUM: one data bit is consumed per bit_valid.
  - WAIT_PAR: waits for par_sample_valid.
- Length rule: data_len latched as 0 or greater than DATA_WIDTH is treated as DATA_WIDTH.
- IDLE + start:
  - latch PAR_EN, PAR_MODE and the effective length;
  - clear the accumulator and count; clear par_ready and par_err;
  - next state ACCUM.
- ACCUM + bit_valid:
  - acc <= acc ^ bit_in; cnt <= cnt + 1.
  - Cycles without bit_valid hold all state; bit gaps of any length are legal.
- Last data bit (bit_valid with cnt == len-1), on the next clock edge:
  - par_bit is set by mode: even = acc^bit_in; odd = ~(acc^bit_in); mark = 1; space = 0.
  - par_ready <= 1.
  - Latched PAR_EN = 1: go to WAIT_PAR.
  - Latched PAR_EN = 0: done pulses, par_err stays 0, go to IDLE.
- Latency: par_bit/par_ready are valid 1 cycle after the last bit_valid.
- WAIT_PAR + par_sample_valid:
  - par_err <= (par_sample != par_bit);
  - done pulses next cycle-edge (same edge as par_err update);
  - go to IDLE.
- par_bit, par_ready and par_err hold until the next start.
- start while busy aborts the current frame and restarts exactly as from IDLE; no done pulse for the aborted frame.
- start together with bit_valid: start wins and the bit is discarded.
- par_sample_valid in IDLE or ACCUM is ignored; bit_valid in IDLE or WAIT_PAR is ignored.
- Mark/space modes still count data bits, so frame timing is unchanged.
- Reset asserted mid-frame returns everything to reset values immediately (asynchronous).

Optional Feature:
Macro PARITY_ERR_CNT_EN.
- Defined:
  - adds output err_cnt [ERR_CNT_W-1:0], reset 0;
  - increments on each par_err=1 update and saturates at all-ones;
  - adds input err_cnt_clr (1 bit), a synchronous clear; clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package uart_pkg:
  - localparams PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11;
  - state encoding ST_IDLE, ST_ACCUM, ST_WAIT_PAR;
  - a LEN_W calculation function.
- One natural sub-module: par_err_counter (saturating counter with clear), instantiated only under PARITY_ERR_CNT_EN.

Test Plan:
- Even, len 8, PAR_EN=1, bits 1,0,1,1,0,0,0,0 (LSB first), par_sample=1 -> par_bit=1 one cycle after the 8th bit; par_err=0; done pulses once.
- Odd, len 5, bits 1,1,0,0,0, par_sample=0 -> par_bit=1, par_err=1; with PARITY_ERR_CNT_EN, err_cnt=1.
- Mark, then space, len 7, any data -> par_bit=1, then 0; gaps of 3 idle cycles between bit_valid pulses do not change the result.
- PAR_EN=0, len 0 (treated as 8) -> done 1 cycle after the 8th bit; no WAIT_PAR; par_err=0; par_sample_valid pulse ignored.
- start re-pulsed after 3 bits, then a full 8-bit even frame of 8'hFF -> par_bit=0; no done pulse from the aborted frame.
- RST asserted in WAIT_PAR -> par_bit=1, par_ready=0, busy=0 immediately; err_cnt saturates at 255 after 300 forced errors, and err_cnt_clr coincident with an error returns it to 0.
